// File: rtl/multdiv_sequential.sv
// Sequential 32-bit signed multiplier/divider: 32 iterations, one bit per cycle.
// Define MULTDIV_EARLY_DIV0_EN to finish divide-by-zero one cycle after the start.
module multdiv_sequential (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);
    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

    state_t      r_state;
    logic [5:0]  r_count;
    logic [63:0] r_acc;
    logic [63:0] r_mcand;
    logic [31:0] r_shreg;   // multiplier bits (mult) or dividend-in/quotient-out (div)
    logic [31:0] r_rem;
    logic [31:0] r_dvsr;
    logic        r_neg;
    logic        r_div0;
    logic        r_ovf;
`ifdef MULTDIV_EARLY_DIV0_EN
    logic        r_early;
`endif

    logic        w_start;
    logic        w_last;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [63:0] w_acc_next;
    logic [63:0] w_prod_signed;
    logic        w_mul_exc;
    logic [32:0] w_rem_shift;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_quo_next;
    logic [31:0] w_quo_signed;

    assign w_start = ((r_state == S_IDLE) || (r_state == S_DONE)) && (ctrl_MULT ^ ctrl_DIV);
    assign w_last  = (r_count == 6'd31);
    assign w_mag_a = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
    assign w_mag_b = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

    assign w_acc_next    = r_shreg[0] ? (r_acc + r_mcand) : r_acc;
    assign w_prod_signed = r_neg ? (~w_acc_next + 64'd1) : w_acc_next;
    // Overflow when the upper 33 bits are not a pure sign extension.
    assign w_mul_exc     = ~((&w_prod_signed[63:31]) | (~|w_prod_signed[63:31]));

    assign w_rem_shift  = {r_rem, r_shreg[31]};
    assign w_diff       = w_rem_shift - {1'b0, r_dvsr};
    assign w_ge         = ~w_diff[32];
    assign w_quo_next   = {r_shreg[30:0], w_ge};
    assign w_quo_signed = r_neg ? (~w_quo_next + 32'd1) : w_quo_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_count        <= 6'd0;
            r_acc          <= 64'd0;
            r_mcand        <= 64'd0;
            r_shreg        <= 32'd0;
            r_rem          <= 32'd0;
            r_dvsr         <= 32'd0;
            r_neg          <= 1'b0;
            r_div0         <= 1'b0;
            r_ovf          <= 1'b0;
`ifdef MULTDIV_EARLY_DIV0_EN
            r_early        <= 1'b0;
`endif
            data_result    <= 32'd0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    data_resultRDY <= 1'b0;
`ifdef MULTDIV_EARLY_DIV0_EN
                    if (r_early) begin
                        r_early        <= 1'b0;
                        r_state        <= S_DONE;
                        data_result    <= 32'd0;
                        data_exception <= 1'b1;
                        data_resultRDY <= 1'b1;
                    end else
`endif
                    if (w_start) begin
                        r_count <= 6'd0;
                        r_neg   <= data_operandA[31] ^ data_operandB[31];
                        if (ctrl_MULT) begin
                            r_acc   <= 64'd0;
                            r_mcand <= {32'd0, w_mag_a};
                            r_shreg <= w_mag_b;
                            r_state <= S_MULT;
                            busy    <= 1'b1;
                        end else begin
                            r_rem   <= 32'd0;
                            r_shreg <= w_mag_a;
                            r_dvsr  <= w_mag_b;
                            r_div0  <= (data_operandB == 32'd0);
                            r_ovf   <= (data_operandA == 32'h8000_0000) &&
                                       (data_operandB == 32'hFFFF_FFFF);
`ifdef MULTDIV_EARLY_DIV0_EN
                            if (data_operandB == 32'd0) begin
                                r_early <= 1'b1;
                                r_state <= S_IDLE;
                                busy    <= 1'b0;
                            end else begin
                                r_state <= S_DIV;
                                busy    <= 1'b1;
                            end
`else
                            r_state <= S_DIV;
                            busy    <= 1'b1;
`endif
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_MULT: begin
                    r_acc   <= w_acc_next;
                    r_mcand <= {r_mcand[62:0], 1'b0};
                    r_shreg <= {1'b0, r_shreg[31:1]};
                    r_count <= r_count + 6'd1;
                    if (w_last) begin
                        r_count        <= 6'd0;
                        r_state        <= S_DONE;
                        busy           <= 1'b0;
                        data_result    <= w_prod_signed[31:0];
                        data_exception <= w_mul_exc;
                        data_resultRDY <= 1'b1;
                    end
                end
                S_DIV: begin
                    r_rem   <= w_ge ? w_diff[31:0] : w_rem_shift[31:0];
                    r_shreg <= w_quo_next;
                    r_count <= r_count + 6'd1;
                    if (w_last) begin
                        r_count        <= 6'd0;
                        r_state        <= S_DONE;
                        busy           <= 1'b0;
                        data_result    <= r_div0 ? 32'd0 : w_quo_signed;
                        data_exception <= r_div0 | r_ovf;
                        data_resultRDY <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/multdiv_sequential.md
MULTDIV_SEQUENTIAL -- requirements
Module: multdiv_sequential

Interface
REQ-001 SHALL have port: clock  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have port: data_operandA  in  32  dividend / multiplicand, two's complement.
REQ-004 SHALL have port: data_operandB  in  32  divisor / multiplier, two's complement.
REQ-005 SHALL have port: ctrl_MULT  in  1  start-multiply request, sampled in IDLE or DONE only.
REQ-006 SHALL have port: ctrl_DIV  in  1  start-divide request, sampled in IDLE or DONE only.
REQ-007 SHALL have port: data_result  out  32  registered result, held until next accepted start.
REQ-008 SHALL have port: data_exception  out  1  registered exception flag, valid with data_result.
REQ-009 SHALL have port: data_resultRDY  out  1  one-cycle completion pulse.
REQ-010 SHALL have port: busy  out  1  high in MULT and DIV states.

Function
REQ-011 SHALL implement states IDLE, MULT, DIV, DONE; reset state IDLE.
REQ-012 Start accepted at edge E0 when state is IDLE or DONE and exactly one of ctrl_MULT/ctrl_DIV is high; operands latched at E0.
REQ-013 Both ctrl_MULT and ctrl_DIV high in the same cycle SHALL be ignored: no state change, outputs unchanged.
REQ-014 Requests while in MULT or DIV SHALL be ignored; the operation in flight is unaffected.
REQ-015 Iteration k (k=1..32) SHALL occur at edge Ek; 6-bit counter, one bit per cycle.
REQ-016 At E32: result and exception registered, state -> DONE, data_resultRDY=1; at E33: state -> IDLE (or MULT/DIV on new start), data_resultRDY=0.
REQ-017 Latency: data_resultRDY high during exactly the cycle between E32 and E33; back-to-back start in DONE cycle SHALL be accepted.
REQ-018 Multiply: magnitudes via shift-add on 32x32 unsigned, 64-bit product negated if operand signs differ; data_result = low 32 bits.
REQ-019 Multiply exception SHALL be 1 iff the signed 64-bit product is not the sign extension of its low 32 bits.
REQ-020 Divide: restoring shift-subtract on magnitudes; quotient truncated toward zero, negated if signs differ; remainder discarded.
REQ-021 Divide by zero SHALL give data_result=0, data_exception=1.
REQ-022 Divide 0x80000000 / 0xFFFFFFFF SHALL give data_result=0x80000000, data_exception=1.
REQ-023 data_result and data_exception SHALL change only at the completion edge or reset; stable across busy period.

Reset
REQ-024 Reset assertion at any time, including mid-operation, SHALL abort the operation and force state IDLE, counter 0.
REQ-025 Reset values: data_result=0, data_exception=0, data_resultRDY=0, busy=0.
REQ-026 First start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-027 Macro MULTDIV_EARLY_DIV0_EN defined: divide with data_operandB=0 at E0 SHALL go directly to DONE at E1 (result 0, exception 1, data_resultRDY high between E1 and E2), never entering DIV.
REQ-028 Macro MULTDIV_EARLY_DIV0_EN undefined: divide by zero SHALL run full 32 iterations, completion per REQ-016.

Verification
REQ-029 ctrl_MULT pulse, A=7, B=-6 -> data_resultRDY after 32 cycles, data_result=0xFFFFFFD6, data_exception=0, busy high 32 cycles.
REQ-030 ctrl_MULT, A=0x00010000, B=0x00010000 -> data_result=0, data_exception=1.
REQ-031 ctrl_DIV, A=-17, B=5 -> data_result=0xFFFFFFFD, exception 0; then ctrl_DIV asserted in DONE cycle with A=100, B=7 -> accepted, result 14 after 32 more cycles.
REQ-032 ctrl_DIV, A=5, B=0 -> result 0, exception 1; completion at 1 cycle with MULTDIV_EARLY_DIV0_EN, 32 cycles without.
REQ-033 Start ctrl_MULT, assert reset at cycle 10 -> all outputs 0 immediately, no data_resultRDY; new ctrl_DIV A=9, B=3 after release -> result 3.
REQ-034 ctrl_MULT and ctrl_DIV high together in IDLE -> busy stays 0, no data_resultRDY; ctrl_DIV pulse at cycle 5 of a multiply -> ignored, multiply result correct.
